enc_rr_arbiter: RTL and testbench

ENC_RR_ARBITER -- requirements
Module: enc_rr_arbiter

---
 rtl/enc_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_enc_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/enc_rr_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grant and binary index.
// Optional forced release after HOLD_MAX grant cycles when ENC_ARB_TIMEOUT_EN is defined.
module enc_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] ptr;
    logic [1:0] ptr_next;
    logic [3:0] gnt_next;
    logic [1:0] gnt_idx_next;
    logic       timeout_next;
    logic       release_now;
    logic       force_release;
    logic       found;
    logic [1:0] winner;

`ifdef ENC_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_limit;

    assign hold_limit    = 8'(HOLD_MAX - 1);
    assign force_release = (state == GRANT) && (hold_cnt == hold_limit);
`else
    assign force_release = 1'b0;
`endif

    assign release_now = done || !req[gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            ptr       <= 2'd0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            gnt       <= gnt_next;
            gnt_idx   <= gnt_idx_next;
            ptr       <= ptr_next;
            timeout   <= timeout_next;
        end
    end

`ifdef ENC_ARB_TIMEOUT_EN
    // Counter restarts on every grant so each holder gets a fresh budget.
    always_ff @(posedge clk) begin
        if (rst || state != GRANT) begin
            hold_cnt <= 8'd0;
        end else begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != 4'b0000) state_next = GRANT;
            GRANT:   if (release_now || force_release) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // First asserted line at or after ptr, wrapping modulo 4.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                found  = 1'b1;
                winner = ptr + 2'(i);
            end
        end
    end

    always_comb begin
        gnt_next     = gnt;
        gnt_idx_next = gnt_idx;
        ptr_next     = ptr;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                gnt_next     = 4'b0000;
                gnt_idx_next = 2'd0;
                if (found) begin
                    gnt_next     = 4'b0001 << winner;
                    gnt_idx_next = winner;
                end
            end
            GRANT: begin
                if (release_now || force_release) begin
                    gnt_next     = 4'b0000;
                    gnt_idx_next = 2'd0;
                    ptr_next     = gnt_idx + 2'd1;
                    timeout_next = force_release && !release_now;
                end
            end
            default: begin
                gnt_next     = 4'b0000;
                gnt_idx_next = 2'd0;
            end
        endcase
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Directed self-checking bench for enc_rr_arbiter (HOLD_MAX=4).
// Timeout expectations follow ENC_ARB_TIMEOUT_EN when the bench is built with it.
module tb_enc_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int vectors;
    int miscompares;

    enc_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, let one rising edge pass, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic [3:0] q, input logic d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                               input logic ev, input logic et);
        logic [7:0] observed;
        logic [7:0] expected;
        observed = {gnt, gnt_idx, gnt_valid, timeout};
        expected = {eg, ei, ev, et};
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s gnt/idx/valid/timeout got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                   tag, gnt, gnt_idx, gnt_valid, timeout, eg, ei, ev, et);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        applyStimulus(1'b1, 4'b1111, 1'b1);
        checkOutput("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Full request set rotates through all lines with an idle gap.
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("rr_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("rr_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_rel1", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("rr_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_rel2", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("rr_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_rel3", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("rr_g0_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Fresh reset: line 2 alone, held; other lines do not disturb it.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("reset2", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("hold_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("hold_g2_b", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0101, 1'b0);
        checkOutput("hold_other_req", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Line 3 grant then release with lines 0 and 3 both asking: ptr wraps to 0.
        applyStimulus(1'b0, 4'b1000, 1'b1);
        checkOutput("rel_to3", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkOutput("g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("g3_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1001, 1'b0);
        checkOutput("wrap_g0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Dropping the granted request releases without done.
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("req_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("idle_after_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

        // ptr is now 1: with lines 0 and 3 asking, line 3 wins over line 0.
        applyStimulus(1'b0, 4'b1001, 1'b0);
        checkOutput("ptr1_scan", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("ptr1_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a grant on line 2.
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("pre_rst_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkOutput("mid_grant_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0110, 1'b0);
        checkOutput("post_rst_g1", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Single requester with done every grant: grant every other cycle.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("reset3", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("single_a", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("single_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("single_c", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("single_d", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Done on the limit edge: normal release wins, no timeout pulse.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("reset4", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("lim_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("lim_hold4", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b1);
        checkOutput("lim_done_wins", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Long hold on line 1 with done low.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("to_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("to_c2", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("to_c3", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("to_c4", 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef ENC_ARB_TIMEOUT_EN
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("persist_c5", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("persist_c6", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
